// File: rtl/conv2d_stream_if.sv
// Streaming pixel-in / result-out handshake bundle for conv2d_stream.
// The master side feeds pixels and consumes results; the slave side is the engine.
interface conv2d_stream_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv2d_stream.sv
// K x K streaming 2-D convolution engine.
// A whole frame is buffered, then convolved one output per cycle (valid or
// zero-padded same mode, optional ReLU) and streamed out in raster order
// through a single backpressured output register.
module conv2d_stream #(
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 4,
    parameter int ACC_W  = 20,
    localparam int CA_W  = (K * K > 1) ? $clog2(K * K) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     cfg_pad,
    input  logic                     cfg_relu,
    input  logic                     coef_we,
    input  logic [CA_W-1:0]          coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     busy,
    output logic                     done,
    conv2d_stream_if.slave           stream
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PA_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int DIM_MX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int RC_W   = $clog2(DIM_MX + 1);
    localparam int HALF   = K / 2;
    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_DONE
    } state_t;

    state_t                    state;
    logic                      pad;
    logic                      relu;
    logic [PA_W-1:0]           wr_addr;
    logic [RC_W-1:0]           row;
    logic [RC_W-1:0]           col;
    logic                      issued_all;
    logic signed [DATA_W-1:0]  buffer [NPIX];
    logic signed [COEF_W-1:0]  coef [K*K];
    logic signed [ACC_W-1:0]   win_sum;
    logic [RC_W-1:0]           last_row;
    logic [RC_W-1:0]           last_col;
    logic                      at_end;
    logic                      coef_addr_ok;

    // Negative results are clamped to zero when ReLU is enabled.
    function automatic logic signed [ACC_W-1:0] apply_relu(
        input logic signed [ACC_W-1:0] v,
        input logic                    en
    );
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    assign last_row     = pad ? RC_W'(IMG_H - 1) : RC_W'(IMG_H - K);
    assign last_col     = pad ? RC_W'(IMG_W - 1) : RC_W'(IMG_W - K);
    assign at_end       = (row == last_row) && (col == last_col);
    assign coef_addr_ok = {1'b0, coef_addr} < (CA_W + 1)'(K * K);

    // Coefficient bank: cleared by reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            coef <= '{default: '0};
        end else if (state == S_IDLE && coef_we && coef_addr_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Frame buffer fill in raster order; contents need no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && stream.in_valid && stream.in_ready) begin
            buffer[wr_addr] <= stream.in_data;
        end
    end

    // Window multiply-accumulate for the output at (row, col); taps outside the image read as zero.
    always_comb begin : window_mac
        int                       org;
        int                       pr;
        int                       pc;
        logic [PA_W-1:0]          idx;
        logic signed [PROD_W-1:0] prod;
        win_sum = '0;
        org     = pad ? HALF : 0;
        pr      = 0;
        pc      = 0;
        idx     = '0;
        prod    = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                pr = int'(row) + r - org;
                pc = int'(col) + c - org;
                if (pr >= 0 && pr < IMG_H && pc >= 0 && pc < IMG_W) begin
                    idx     = PA_W'(pr * IMG_W + pc);
                    prod    = buffer[idx] * coef[CA_W'(r * K + c)];
                    win_sum = win_sum + ACC_W'(prod);
                end
            end
        end
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            pad              <= 1'b0;
            relu             <= 1'b0;
            wr_addr          <= '0;
            row              <= '0;
            col              <= '0;
            issued_all       <= 1'b0;
            stream.in_ready  <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            stream.out_data  <= '0;
            done             <= 1'b0;
            busy             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pad             <= cfg_pad;
                        relu            <= cfg_relu;
                        wr_addr         <= '0;
                        stream.in_ready <= 1'b1;
                        busy            <= 1'b1;
                        state           <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (stream.in_valid && stream.in_ready) begin
                        if (wr_addr == PA_W'(NPIX - 1)) begin
                            stream.in_ready <= 1'b0;
                            wr_addr         <= '0;
                            row             <= '0;
                            col             <= '0;
                            issued_all      <= 1'b0;
                            state           <= S_CONV;
                        end else begin
                            wr_addr <= wr_addr + PA_W'(1);
                        end
                    end
                end
                S_CONV: begin
                    // The output register may only change when empty or being drained.
                    if (!stream.out_valid || stream.out_ready) begin
                        if (stream.out_valid && stream.out_last) begin
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                            done             <= 1'b1;
                            state            <= S_DONE;
                        end else if (!issued_all) begin
                            stream.out_data  <= apply_relu(win_sum, relu);
                            stream.out_valid <= 1'b1;
                            stream.out_last  <= at_end;
                            if (at_end) begin
                                issued_all <= 1'b1;
                            end
                            if (col == last_col) begin
                                col <= '0;
                                row <= (row == last_row) ? '0 : row + RC_W'(1);
                            end else begin
                                col <= col + RC_W'(1);
                            end
                        end else begin
                            stream.out_valid <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: table-driven frames, hand sequences for
// backpressure / reset / ignored controls, and random frames checked against
// a direct-definition convolution model.
module tb_conv2d_stream;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int K  = 3;
    localparam int NP = W * H;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               cfg_pad;
    logic               cfg_relu;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [3:0]  coef_data;
    logic               busy;
    logic               done;

    conv2d_stream_if #(.DATA_W(8), .ACC_W(20)) bus ();

    conv2d_stream #(
        .IMG_W(W), .IMG_H(H), .K(K), .DATA_W(8), .COEF_W(4), .ACC_W(20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_pad   (cfg_pad),
        .cfg_relu  (cfg_relu),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .done      (done),
        .stream    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int kern_sel;
        int pix;
        bit pad;
        bit relu;
        int rmode;
        int exp_n;
        int exp_first;
        int mid_idx;
        int exp_mid;
        int mid2_idx;
        int exp_mid2;
        int exp_end;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   tk[9] = '{0, 1, 2, 2, 2, 0, 0, 1, 2};
    int   kern[9];
    int   frame[NP];
    int   exp_q[$];
    int   got_q[$];
    bit   lastf_q[$];
    vec_t vecs[4];

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Convolution straight from its definition: sum over the window, zero outside the image.
    function automatic void model(input bit pad, input bit relu);
        int oh, ow, off, s, pr, pc;
        oh  = pad ? H : H - K + 1;
        ow  = pad ? W : W - K + 1;
        off = pad ? K / 2 : 0;
        exp_q.delete();
        for (int i = 0; i < oh; i++) begin
            for (int j = 0; j < ow; j++) begin
                s = 0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        pr = i + r - off;
                        pc = j + c - off;
                        if (pr >= 0 && pr < H && pc >= 0 && pc < W)
                            s += kern[r * K + c] * frame[pr * W + pc];
                    end
                end
                if (relu && s < 0) s = 0;
                exp_q.push_back(s);
            end
        end
    endfunction

    task automatic load_kernel();
        for (int i = 0; i < K * K; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = 4'(kern[i]);
            step();
        end
        coef_we = 1'b0;
    endtask

    // rmode: 0 ready high, 1 random, 2 toggle, 3 hold low for 3 valid cycles then toggle.
    task automatic run_frame(input bit pad, input bit relu, input int rmode,
                             input bit poke_coef, input bit poke_start);
        int n, cyc, hold, d, pv_d;
        bit fin, r, v, l, prev_stall, pv_l, tog, poked;
        got_q.delete();
        lastf_q.delete();
        cfg_pad  = pad;
        cfg_relu = relu;
        start    = 1'b1;
        step();
        start = 1'b0;
        n = 0; cyc = 0; poked = 0;
        while (n < NP && cyc < 1000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = 8'(frame[n]);
            coef_we      = 1'b0;
            if (poke_coef && n == 10 && !poked) begin
                coef_we   = 1'b1;
                coef_addr = 4'd0;
                coef_data = 4'sd7;
                poked     = 1;
            end
            r = bus.in_ready;
            step();
            cyc++;
            if (bus.in_valid && r) n++;
        end
        bus.in_valid = 1'b0;
        coef_we      = 1'b0;
        chk("load_count", n, NP);
        fin = 0; cyc = 0; hold = 0; prev_stall = 0; tog = 0; poked = 0;
        pv_d = 0; pv_l = 0;
        while (!fin && cyc < 1000) begin
            v = bus.out_valid;
            d = bus.out_data;
            l = bus.out_last;
            if (prev_stall) begin
                chk("hold_valid", v, 1);
                chk("hold_data", d, pv_d);
                chk("hold_last", l, pv_l);
            end
            case (rmode)
                0: r = 1;
                1: r = 1'($urandom_range(0, 1));
                2: begin r = tog; tog = !tog; end
                default: begin
                    if (hold < 3) begin
                        r = 0;
                        if (v) hold++;
                    end else begin
                        r = tog;
                        tog = !tog;
                    end
                end
            endcase
            start = 1'b0;
            if (poke_start && got_q.size() == 3 && !poked) begin
                start = 1'b1;
                poked = 1;
            end
            bus.out_ready = r;
            prev_stall = v && !r;
            pv_d = d;
            pv_l = l;
            step();
            cyc++;
            start = 1'b0;
            if (v && r) begin
                got_q.push_back(d);
                lastf_q.push_back(l);
                if (l) fin = 1;
            end
        end
        bus.out_ready = 1'b0;
        chk("frame_complete", fin, 1);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        step();
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
        chk("in_ready_idle", bus.in_ready, 0);
        model(pad, relu);
        chk("result_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            chk($sformatf("result[%0d]", k), got_q[k], exp_q[k]);
            chk($sformatf("last_flag[%0d]", k), lastf_q[k], (k == exp_q.size() - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, cyc;
        bit r;

        vecs[0] = '{kern_sel: 0, pix: 1, pad: 0, relu: 0, rmode: 0, exp_n: 16,
                    exp_first: 10, mid_idx: 5, exp_mid: 10, mid2_idx: 15, exp_mid2: 10, exp_end: 10};
        vecs[1] = '{kern_sel: 0, pix: 1, pad: 1, relu: 0, rmode: 0, exp_n: 36,
                    exp_first: 5, mid_idx: 5, exp_mid: 5, mid2_idx: 14, exp_mid2: 10, exp_end: 5};
        vecs[2] = '{kern_sel: 1, pix: -128, pad: 0, relu: 0, rmode: 1, exp_n: 16,
                    exp_first: -8064, mid_idx: 5, exp_mid: -8064, mid2_idx: 15, exp_mid2: -8064, exp_end: -8064};
        vecs[3] = '{kern_sel: 1, pix: -128, pad: 0, relu: 1, rmode: 1, exp_n: 16,
                    exp_first: 0, mid_idx: 5, exp_mid: 0, mid2_idx: 15, exp_mid2: 0, exp_end: 0};

        reset = 1'b1; start = 1'b0; cfg_pad = 1'b0; cfg_relu = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // Table-driven frames
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < K * K; i++) kern[i] = (vecs[t].kern_sel == 0) ? tk[i] : 7;
            for (int i = 0; i < NP; i++) frame[i] = vecs[t].pix;
            load_kernel();
            run_frame(vecs[t].pad, vecs[t].relu, vecs[t].rmode, 0, 0);
            chk($sformatf("vec%0d_count", t), got_q.size(), vecs[t].exp_n);
            if (got_q.size() == vecs[t].exp_n) begin
                chk($sformatf("vec%0d_first", t), got_q[0], vecs[t].exp_first);
                chk($sformatf("vec%0d_mid", t), got_q[vecs[t].mid_idx], vecs[t].exp_mid);
                chk($sformatf("vec%0d_mid2", t), got_q[vecs[t].mid2_idx], vecs[t].exp_mid2);
                chk($sformatf("vec%0d_end", t), got_q[vecs[t].exp_n - 1], vecs[t].exp_end);
            end
        end

        // Backpressure: identity-centre kernel over a ramp frame
        for (int i = 0; i < K * K; i++) kern[i] = (i == 4) ? 1 : 0;
        for (int i = 0; i < NP; i++) frame[i] = i;
        load_kernel();
        run_frame(0, 0, 3, 0, 0);
        if (got_q.size() >= 5) begin
            chk("bp_first", got_q[0], 7);
            chk("bp_row1", got_q[4], 13);
        end

        // Reset in the middle of LOAD, then reset together with start/coef_we in IDLE
        for (int i = 0; i < K * K; i++) kern[i] = tk[i];
        load_kernel();
        cfg_pad = 1'b0; cfg_relu = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 20 && cyc < 200) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(n);
            r = bus.in_ready;
            step();
            cyc++;
            if (r) n++;
        end
        chk("midload_count", n, 20);
        bus.in_valid = 1'b0;
        reset = 1'b1; start = 1'b1; coef_we = 1'b1; coef_addr = 4'd4; coef_data = 4'sd3;
        step();
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        step();
        reset = 1'b0; start = 1'b0; coef_we = 1'b0;
        step();
        chk("rst_dom_busy", busy, 0);
        chk("rst_dom_in_ready", bus.in_ready, 0);
        for (int i = 0; i < K * K; i++) kern[i] = 0;
        for (int i = 0; i < NP; i++) frame[i] = $urandom_range(0, 255) - 128;
        run_frame(0, 0, 1, 0, 0);
        chk("zero_frame_count", got_q.size(), 16);

        // Ignored controls: out-of-range coef writes, coef_we during LOAD, start during CONV
        for (int i = 0; i < K * K; i++) kern[i] = tk[i];
        for (int i = 0; i < NP; i++) frame[i] = 1;
        load_kernel();
        for (int a = 9; a < 16; a++) begin
            coef_we = 1'b1; coef_addr = 4'(a); coef_data = 4'sd7;
            step();
        end
        coef_we = 1'b0;
        run_frame(0, 0, 0, 1, 1);
        if (got_q.size() > 0) chk("ign_first", got_q[0], 10);
        run_frame(0, 0, 0, 0, 0);
        if (got_q.size() > 0) chk("ign_next_first", got_q[0], 10);

        // Random kernels, frames, modes and backpressure
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < K * K; i++) kern[i] = $urandom_range(0, 15) - 8;
            for (int i = 0; i < NP; i++) frame[i] = $urandom_range(0, 255) - 128;
            load_kernel();
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
